// File: rtl/video_framebuffer.sv
// video_framebuffer: single-clock pixel framebuffer addressed by (x,y).
// Out-of-range writes are dropped and flagged with wr_oob. Out-of-range reads
// return zero. The read port is registered with a valid strobe, and a
// clear-screen engine fills one pixel per cycle while busy is high.
// Optional feature macro: FRAMEBUF_DOUBLE_EN enables two pages. Writes and
// clears target the back page, reads target the front page, and swap_req
// flips the pages. A swap requested during a clear is deferred until the
// clear finishes.
module video_framebuffer #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int PIXEL_BITS = 3,
    parameter int XW         = $clog2(WIDTH),
    parameter int YW         = $clog2(HEIGHT)
) (
    input  logic                  clk_write,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [XW-1:0]         wr_x,
    input  logic [YW-1:0]         wr_y,
    input  logic [PIXEL_BITS-1:0] wr_data,
    output logic                  wr_oob,
    input  logic                  rd_en,
    input  logic [XW-1:0]         rd_x,
    input  logic [YW-1:0]         rd_y,
    output logic [PIXEL_BITS-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  clear_req,
    input  logic [PIXEL_BITS-1:0] clear_color,
    output logic                  busy,
    input  logic                  swap_req,
    output logic                  front_page
);

    localparam int PIXELS = WIDTH * HEIGHT;
`ifdef FRAMEBUF_DOUBLE_EN
    localparam int DEPTH = 2 * PIXELS;
`else
    localparam int DEPTH = PIXELS;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(PIXELS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PIXELS - 1);
    localparam logic [AW-1:0] PAGE_OFS = AW'(PIXELS);

    logic [0:0]            state_r;
    logic [CW-1:0]         clr_cnt_r;
    logic [PIXEL_BITS-1:0] clr_color_r;
    logic                  wr_oob_r;
    logic                  rd_valid_r;
    logic [PIXEL_BITS-1:0] rd_data_r;

    logic [PIXEL_BITS-1:0] mem [0:DEPTH-1];

    logic                  wr_fire_s;
    logic                  wr_in_range_s;
    logic                  rd_in_range_s;
    logic                  clr_last_s;
    logic                  back_page_s;
    logic                  read_page_s;
    logic [AW-1:0]         wr_addr_s;
    logic [AW-1:0]         rd_addr_s;
    logic [AW-1:0]         clr_addr_s;

    assign wr_ready      = (state_r == ST_IDLE);
    assign busy          = (state_r == ST_CLEAR);
    assign wr_fire_s     = wr_valid && (state_r == ST_IDLE);
    assign wr_in_range_s = (int'(wr_x) < WIDTH) && (int'(wr_y) < HEIGHT);
    assign rd_in_range_s = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
    assign clr_last_s    = (state_r == ST_CLEAR) && (clr_cnt_r == CNT_LAST);

    // Linear addresses: row-major offset within a page plus the page base.
    always_comb begin
        wr_addr_s  = AW'(wr_y) * AW'(WIDTH) + AW'(wr_x);
        rd_addr_s  = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);
        clr_addr_s = AW'(clr_cnt_r);
        if (back_page_s) begin
            wr_addr_s  = wr_addr_s + PAGE_OFS;
            clr_addr_s = clr_addr_s + PAGE_OFS;
        end else begin
            clr_addr_s = clr_addr_s;
        end
        if (read_page_s) begin
            rd_addr_s = rd_addr_s + PAGE_OFS;
        end else begin
            rd_addr_s = rd_addr_s;
        end
    end

    // Clear engine: IDLE/CLEAR sequencing, sweep counter and latched colour.
    always_ff @(posedge clk_write or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            clr_cnt_r   <= {CW{1'b0}};
            clr_color_r <= {PIXEL_BITS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_r     <= ST_CLEAR;
                        clr_cnt_r   <= {CW{1'b0}};
                        clr_color_r <= clear_color;
                    end
                end
                ST_CLEAR: begin
                    if (clr_last_s) begin
                        state_r   <= ST_IDLE;
                        clr_cnt_r <= {CW{1'b0}};
                    end else begin
                        clr_cnt_r <= clr_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clr_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Pixel storage: the clear sweep owns the RAM while busy, else the write port.
    always_ff @(posedge clk_write) begin
        if (state_r == ST_CLEAR) begin
            mem[clr_addr_s] <= clr_color_r;
        end else if (wr_fire_s && wr_in_range_s) begin
            mem[wr_addr_s] <= wr_data;
        end
    end

    // Flag an accepted write whose coordinates fell outside the frame.
    always_ff @(posedge clk_write or posedge reset) begin
        if (reset) begin
            wr_oob_r <= 1'b0;
        end else begin
            wr_oob_r <= wr_fire_s && !wr_in_range_s;
        end
    end

    // Registered read port: read-first, zero for out-of-range, hold when idle.
    always_ff @(posedge clk_write or posedge reset) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {PIXEL_BITS{1'b0}};
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                if (rd_in_range_s) begin
                    rd_data_r <= mem[rd_addr_s];
                end else begin
                    rd_data_r <= {PIXEL_BITS{1'b0}};
                end
            end
        end
    end

`ifdef FRAMEBUF_DOUBLE_EN
    logic front_r;
    logic swap_pend_r;
    logic swap_want_s;

    assign swap_want_s = swap_req || swap_pend_r;

    // Page flip: immediate when idle, otherwise held until the clear's final edge.
    always_ff @(posedge clk_write or posedge reset) begin
        if (reset) begin
            front_r     <= 1'b0;
            swap_pend_r <= 1'b0;
        end else if (swap_want_s && ((state_r == ST_IDLE) || clr_last_s)) begin
            front_r     <= ~front_r;
            swap_pend_r <= 1'b0;
        end else if (swap_req) begin
            swap_pend_r <= 1'b1;
        end
    end

    assign back_page_s = ~front_r;
    assign read_page_s = front_r;
    assign front_page  = front_r;
`else
    logic unused_swap_s;

    assign unused_swap_s = swap_req;
    assign back_page_s   = 1'b0;
    assign read_page_s   = 1'b0;
    assign front_page    = 1'b0;
`endif

    assign wr_oob   = wr_oob_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_video_framebuffer.sv
// tb_video_framebuffer: directed plus randomized checks of video_framebuffer
// against a page/array reference model. Build with FRAMEBUF_DOUBLE_EN
// defined to exercise the double-buffered variant.
module tb_video_framebuffer;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int PB     = 3;
    localparam int XW     = 8;
    localparam int YW     = 7;
    localparam int PIX    = WIDTH * HEIGHT;
`ifdef FRAMEBUF_DOUBLE_EN
    localparam int NP = 2;
`else
    localparam int NP = 1;
`endif

    logic          clk_write = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [PB-1:0] wr_data;
    logic          wr_oob;
    logic          rd_en;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [PB-1:0] rd_data;
    logic          rd_valid;
    logic          clear_req;
    logic [PB-1:0] clear_color;
    logic          busy;
    logic          swap_req;
    logic          front_page;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one array per page, plus a known flag per pixel.
    logic [PB-1:0] m_mem   [0:NP*PIX-1];
    bit            m_known [0:NP*PIX-1];
    int            m_front = 0;

    video_framebuffer dut (
        .clk_write   (clk_write),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .wr_oob      (wr_oob),
        .rd_en       (rd_en),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .busy        (busy),
        .swap_req    (swap_req),
        .front_page  (front_page)
    );

    always #5 clk_write = ~clk_write;

    task automatic tick();
        @(posedge clk_write);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input int x, input int y);
        return (x < WIDTH) && (y < HEIGHT);
    endfunction

    function automatic int back_page();
        return (NP == 2) ? (1 - m_front) : 0;
    endfunction

    function automatic int read_page();
        return (NP == 2) ? m_front : 0;
    endfunction

    task automatic m_write(input int x, input int y, input logic [PB-1:0] d);
        if (in_range(x, y)) begin
            m_mem[back_page() * PIX + y * WIDTH + x]   = d;
            m_known[back_page() * PIX + y * WIDTH + x] = 1'b1;
        end
    endtask

    task automatic m_fill(input logic [PB-1:0] c);
        for (int a = 0; a < PIX; a++) begin
            m_mem[back_page() * PIX + a]   = c;
            m_known[back_page() * PIX + a] = 1'b1;
        end
    endtask

    task automatic m_read(input int x, input int y, output logic [PB-1:0] v, output bit k);
        if (!in_range(x, y)) begin
            v = 3'd0;
            k = 1'b1;
        end else begin
            v = m_mem[read_page() * PIX + y * WIDTH + x];
            k = m_known[read_page() * PIX + y * WIDTH + x];
        end
    endtask

    function automatic int rand_x();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(WIDTH, 255))
                                           : int'($urandom_range(0, WIDTH - 1));
    endfunction

    function automatic int rand_y();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(HEIGHT, 127))
                                           : int'($urandom_range(0, HEIGHT - 1));
    endfunction

    task automatic do_write(input int x, input int y, input logic [PB-1:0] d);
        wr_valid = 1'b1;
        wr_x     = XW'(x);
        wr_y     = YW'(y);
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
        m_write(x, y, d);
        chk("wr_oob_pulse", wr_oob, !in_range(x, y));
        tick();
        chk("wr_oob_clear", wr_oob, 1'b0);
    endtask

    task automatic do_read(input int x, input int y);
        logic [PB-1:0] v;
        bit            k;
        m_read(x, y, v, k);
        rd_en = 1'b1;
        rd_x  = XW'(x);
        rd_y  = YW'(y);
        tick();
        rd_en = 1'b0;
        chk("rd_valid", rd_valid, 1'b1);
        if (k) chk("rd_data", rd_data, v);
        tick();
        chk("rd_valid_drop", rd_valid, 1'b0);
        if (k) chk("rd_hold", rd_data, v);
    endtask

    initial begin
        int            n;
        int            ready_bad;
        int            front_bad;
        int            wx, wy, rx, ry;
        bit            wv, rv, ek, hold_k;
        logic [PB-1:0] wd, ev, hold_v;

        reset       = 1'b1;
        wr_valid    = 1'b0;
        wr_x        = 8'd0;
        wr_y        = 7'd0;
        wr_data     = 3'd0;
        rd_en       = 1'b0;
        rd_x        = 8'd0;
        rd_y        = 7'd0;
        clear_req   = 1'b0;
        clear_color = 3'd0;
        swap_req    = 1'b0;
        repeat (3) @(posedge clk_write);
        #1;
        reset = 1'b0;
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_wr_oob", wr_oob, 1'b0);
        chk("rst_front", front_page, 1'b0);

        // Start a clear while reading, then reset asynchronously at cycle 50.
        rd_en       = 1'b1;
        clear_req   = 1'b1;
        clear_color = 3'd3;
        tick();
        clear_req = 1'b0;
        chk("clr_busy_start", busy, 1'b1);
        chk("clr_ready_low", wr_ready, 1'b0);
        chk("rd_valid_pre_rst", rd_valid, 1'b1);
        repeat (49) tick();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_rd_valid", rd_valid, 1'b0);
        chk("arst_rd_data", rd_data, 3'd0);
        chk("arst_wr_ready", wr_ready, 1'b1);
        rd_en = 1'b0;
        @(posedge clk_write);
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("abort_busy", busy, 1'b0);

        // Full clear with colour 2, a write in the same cycle, and an ignored re-request.
        wr_valid    = 1'b1;
        wr_x        = 8'd10;
        wr_y        = 7'd10;
        wr_data     = 3'd7;
        clear_req   = 1'b1;
        clear_color = 3'd2;
        tick();
        m_write(10, 10, 3'd7);
        m_fill(3'd2);
        wr_valid    = 1'b0;
        clear_req   = 1'b0;
        clear_color = 3'd5;
        chk("clear_busy", busy, 1'b1);
        n         = 0;
        ready_bad = 0;
        while (busy === 1'b1 && n < 30000) begin
            if (wr_ready !== 1'b0) ready_bad++;
            if (n == 201) chk("no_oob_while_busy", wr_oob, 1'b0);
            if (n == 19001) begin
                chk("rd_during_clear_valid", rd_valid, 1'b1);
                chk("rd_during_clear_data", rd_data, 3'd2);
            end
            clear_req = (n == 100);
            rd_en     = (n == 19000);
            rd_x      = 8'd0;
            rd_y      = 7'd0;
            wr_valid  = (n == 200);
            wr_x      = 8'd200;
            wr_y      = 7'd3;
            tick();
            n++;
        end
        clear_req = 1'b0;
        rd_en     = 1'b0;
        wr_valid  = 1'b0;
        chk("clear_cycles", n, 19200);
        chk("ready_low_throughout", ready_bad, 0);
        chk("clear_done_ready", wr_ready, 1'b1);
        repeat (3) tick();
        chk("no_restart", busy, 1'b0);

        do_read(0, 0);
        do_read(159, 119);
        do_read(80, 60);
        do_read(10, 10);

        // Directed writes, out-of-range accesses, read-during-write.
        do_write(5, 7, 3'd5);
        do_read(5, 7);
        do_write(160, 0, 3'd7);
        do_read(0, 1);
        do_read(0, 0);
        do_write(3, 120, 3'd6);
        do_read(3, 0);
        do_read(200, 5);

        m_read(9, 9, ev, ek);
        wr_valid = 1'b1;
        wr_x     = 8'd9;
        wr_y     = 7'd9;
        wr_data  = 3'd6;
        rd_en    = 1'b1;
        rd_x     = 8'd9;
        rd_y     = 7'd9;
        tick();
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        m_write(9, 9, 3'd6);
        if (ek) chk("rdw_old_data", rd_data, ev);
        do_read(9, 9);

        // Randomized traffic in IDLE against the model.
        hold_v = rd_data;
        hold_k = 1'b0;
        for (int i = 0; i < 400; i++) begin
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            wx = rand_x();
            wy = rand_y();
            rx = rand_x();
            ry = rand_y();
            wd = 3'($urandom_range(0, 7));
            if (rv) begin
                m_read(rx, ry, ev, ek);
                hold_v = ev;
                hold_k = ek;
            end
            wr_valid = wv;
            wr_x     = XW'(wx);
            wr_y     = YW'(wy);
            wr_data  = wd;
            rd_en    = rv;
            rd_x     = XW'(rx);
            rd_y     = YW'(ry);
            tick();
            if (wv) m_write(wx, wy, wd);
            chk("rand_rd_valid", rd_valid, rv);
            chk("rand_wr_oob", wr_oob, wv && !in_range(wx, wy));
            if (hold_k) chk("rand_rd_data", rd_data, hold_v);
        end
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        tick();

`ifdef FRAMEBUF_DOUBLE_EN
        // Back-page write then swap makes it visible.
        do_write(3, 3, 3'd1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        m_front  = 1;
        chk("swap_front", front_page, 1'b1);
        do_read(3, 3);

        // Swaps requested during a clear are deferred and collapse to one.
        clear_req   = 1'b1;
        clear_color = 3'd4;
        tick();
        clear_req = 1'b0;
        m_fill(3'd4);
        n         = 0;
        front_bad = 0;
        while (busy === 1'b1 && n < 30000) begin
            if (front_page !== 1'b1) front_bad++;
            swap_req = (n == 10) || (n == 20);
            tick();
            n++;
        end
        swap_req = 1'b0;
        m_front  = 0;
        chk("dbl_clear_cycles", n, 19200);
        chk("dbl_front_held", front_bad, 0);
        chk("dbl_front_swapped", front_page, 1'b0);
        repeat (2) tick();
        chk("dbl_single_swap", front_page, 1'b0);
        do_read(0, 0);
        do_read(3, 3);
`else
        // Single-page build: swap_req has no effect.
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swap_ignored", front_page, 1'b0);
        tick();
        chk("swap_ignored_2", front_page, 1'b0);
        do_read(5, 7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
